// File: rtl/bam_seq_mult.sv
// bam_seq_mult: sequential Broken Array Multiplier for unsigned WxW operands.
// One partial-product row is accumulated per cycle. Rows j < HBL and product
// columns i+j < VBL are dropped, which gives the BAM approximation.
// Optional feature macro: BAM_SEQ_SKIP_ZERO_EN. When it is defined, the block
// finishes early once all remaining multiplier bits are zero. The product is
// unchanged; only the latency gets shorter.
module bam_seq_mult #(
  parameter int W   = 8,
  parameter int HBL = 0,
  parameter int VBL = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int RW = (W > 2) ? $clog2(W) : 1;
  localparam logic [2*W-1:0] C_ONE = {{(2*W-1){1'b0}}, 1'b1};
  // Clears product columns below the vertical break level.
  localparam logic [2*W-1:0] C_MASK = ~((C_ONE << VBL) - C_ONE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_acc;
  logic [RW-1:0]    r_row;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [2*W-1:0]   r_p;

  logic [2*W-1:0]   w_a_ext;
  logic [2*W-1:0]   w_row_term;
  logic [2*W-1:0]   w_sum;
  logic             w_last;

  assign w_a_ext = {{W{1'b0}}, r_a};

  // Masked partial-product row for the row currently being processed.
  always_comb begin
    w_row_term = '0;
    if (r_b[r_row]) begin
      w_row_term = (w_a_ext << r_row) & C_MASK;
    end
  end

  assign w_sum = r_acc + w_row_term;

`ifdef BAM_SEQ_SKIP_ZERO_EN
  logic [W-1:0] w_b_hi;

  // Multiplier bits above the current row; when they are all zero, the
  // remaining rows contribute nothing and the block can stop.
  assign w_b_hi = r_b >> (r_row + 1'b1);
  assign w_last = (r_row == RW'(W-1)) || (w_b_hi == '0);
`else
  assign w_last = (r_row == RW'(W-1));
`endif

  // Handshake FSM with the row accumulator; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_row       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_acc      <= '0;
            r_row      <= RW'(HBL);
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= w_sum;
          r_row <= r_row + 1'b1;
          if (w_last) begin
            r_p         <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p         = r_p;

endmodule

// File: doc/bam_seq_mult.md
# bam_seq_mult

Parametrised, multi-cycle Broken Array Multiplier (BAM) for unsigned W×W operands with a valid/ready handshake on both sides. Each cycle it accumulates one partial-product row. Rows below a horizontal break level and columns below a vertical break level are omitted, which yields the standard BAM approximation while trading area for latency. It sits in the approximate-arithmetic library as the sequential, width-generic successor to the fixed 8×8 combinational array multipliers and can be swapped in wherever a handshaked approximate product is needed.

## Interface
- W, default 8: operand width; W ≥ 2.
- HBL, default 0: horizontal break level; multiplier rows j < HBL are omitted; 0 ≤ HBL ≤ W-1.
- VBL, default 0: vertical break level; product columns i+j < VBL are omitted; 0 ≤ VBL ≤ 2W-2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands.
- a  input  W  multiplicand, unsigned.
- b  input  W  multiplier, unsigned.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2W  approximate product, unsigned.

## Operation
- Exact reference: Σ a[i]·b[j]·2^(i+j). The block computes P = Σ a[i]·b[j]·2^(i+j) over j ≥ HBL and i+j ≥ VBL. With HBL=VBL=0, P equals the exact product.
- Row term for row j: b[j] ? ((a << j) & MASK) : 0, where MASK is the 2W-bit value with bits [VBL-1:0] cleared. The accumulator is 2W bits and cannot overflow, because P ≤ exact product < 2^(2W).
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready, latch a and b, clear acc, set row=HBL, go to BUSY.
  - BUSY: in_ready=0. Each cycle acc += rowterm(row) and row++. After row W-1 is processed (or on early termination, see Configuration), go to DONE.
  - DONE: out_valid=1 and p=acc, both held stable. On out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE. a and b may change freely after acceptance.
- Reset (asynchronous, any state, including mid-BUSY) aborts the operation with no output: state=IDLE, in_ready=1, out_valid=0, p=0, acc=0, row=0.

## Timing
- Accept at edge k. Rows are processed on edges k+1..k+N, where N = W-HBL (fixed latency without the macro).
- out_valid rises after edge k+N. With out_ready held at 1, the output handshake occurs at edge k+N+1, and in_ready is 1 after that edge.
- Peak throughput: one product per N+2 cycles.
- Holding out_ready low stalls the block in DONE indefinitely, with p unchanged.
- in_ready is a registered state decode with no combinational path from in_valid or out_ready.

## Configuration
- Macro BAM_SEQ_SKIP_ZERO_EN.
- Defined: in BUSY, after processing row r, go to DONE if b[W-1:r+1] == 0 (latched b). This gives N = max(1, msb(b) - HBL + 1), and N = 1 when b[W-1:HBL] == 0. The result is bit-identical to the non-skip result.
- Undefined: N = W-HBL for every operand pair. No early-exit logic is generated.

## Test plan
- W=8, HBL=0, VBL=0, a=255, b=255, out_ready=1 → out_valid exactly 8 cycles after acceptance, p=65025; in_ready returns 1 cycle after the output handshake.
- W=8, HBL=0, VBL=8, a=255, b=255 → p=63232. Then a=13, b=11 → p=0 (all terms lie in columns < 8).
- W=8, HBL=2, VBL=0, a=255, b=3 → p=0 after 6 cycles. Then a=5, b=12 → p=60.
- Backpressure: after a=200, b=100 completes (p=20000 with HBL=VBL=0), hold out_ready=0 for 5 cycles with in_valid=1 → p stable at 20000, out_valid=1, in_ready=0, and the new operands are not accepted until after the output handshake.
- Reset: assert rst_n=0 on the 3rd BUSY cycle → asynchronously out_valid=0, in_ready=1, p=0. After release, a=7, b=9 → p=63 with no residue from the aborted operation.
- BAM_SEQ_SKIP_ZERO_EN, HBL=0, VBL=0: a=200, b=1 → p=200, out_valid 1 cycle after acceptance (8 cycles without the macro). a=3, b=128 → p=384 after 8 cycles.
